// File: rtl/dtcore32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dtcore32_pkg
// Description : Shared types for the dtcore32 hazard controller. Holds the
//               EX forwarding-mux select encoding and the data-memory wait
//               state machine encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dtcore32_pkg;

    // EX operand forwarding select. The encoding is visible on the
    // EX_forward_*_o ports, so the values are fixed.
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    // Data-memory access tracking: IDLE while no access is pending beyond
    // its first cycle, WAIT while waiting on the acknowledge.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/dtcore32_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : dtcore32_fwd_sel
// Description : Forwarding select for one EX source operand. A write in MEM
//               is younger than a write in WB, so a MEM match wins. Register
//               x0 is hard-wired to zero and is never forwarded.
// Ports       : i_rs_addr        - EX source register address
//               i_mem_rd_addr    - destination register of the MEM instruction
//               i_mem_reg_wr_en  - MEM instruction writes its destination
//               i_wb_rd_addr     - destination register of the WB instruction
//               i_wb_reg_wr_en   - WB instruction writes its destination
//               o_fwd_sel        - forwarding mux select
// Revision    : 1.0 - initial release
// ============================================================================
module dtcore32_fwd_sel
    import dtcore32_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic [AW-1:0] i_rs_addr,
    input  logic [AW-1:0] i_mem_rd_addr,
    input  logic          i_mem_reg_wr_en,
    input  logic [AW-1:0] i_wb_rd_addr,
    input  logic          i_wb_reg_wr_en,
    output fwd_sel_t      o_fwd_sel
);

    logic w_src_nonzero;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_src_nonzero = (i_rs_addr != '0);
    assign w_mem_hit     = i_mem_reg_wr_en & (i_mem_rd_addr == i_rs_addr) & w_src_nonzero;
    assign w_wb_hit      = i_wb_reg_wr_en  & (i_wb_rd_addr  == i_rs_addr) & w_src_nonzero;

    always_comb begin
        o_fwd_sel = FWD_NONE;
        if (w_mem_hit) begin
            o_fwd_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_fwd_sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dtcore32_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dtcore32_hazard_ctrl
// Description : Pipeline hazard controller for the five-stage dtcore32 core.
//               Drives the stall/flush controls of the pipeline registers and
//               the EX forwarding muxes. Handles a variable-latency data
//               memory with timeout, a multi-cycle MDU with abort-on-trap,
//               load-use hazards, branch/jump redirects and traps, and counts
//               front-end stall cycles.
// Ports       : clk_i, rst_i                 - clock, async active-high reset
//               EX/MEM/WB/ID_*_addr_i        - register addresses per stage
//               MEM/WB_reg_wr_en_i           - stage writes its rd
//               ID_rs1/rs2_used_i            - ID instruction reads the source
//               EX_load_i                    - load in EX
//               MEM_dmem_req_i, dmem_ack_i   - data-memory handshake
//               EX_mdu_start_i, mdu_done_i   - MDU handshake
//               EX_pc_src_i                  - taken branch/jump in EX
//               *_trap_valid_i               - trap present in stage
//               EX_forward_a/b_o             - forwarding selects
//               *_stall_o, *_flush_o         - pipeline register controls
//               mdu_kill_o                   - abort in-flight MDU op
//               dmem_timeout_o               - pulse on data-memory timeout
//               stall_cycles_o               - count of IF stall cycles
// Revision    : 1.0 - initial release
// ============================================================================
module dtcore32_hazard_ctrl
    import dtcore32_pkg::*;
#(
    parameter int unsigned AW           = 5,
    parameter int unsigned DMEM_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [AW-1:0]    EX_rs1_addr_i,
    input  logic [AW-1:0]    EX_rs2_addr_i,
    input  logic [AW-1:0]    MEM_rd_addr_i,
    input  logic [AW-1:0]    WB_rd_addr_i,
    input  logic [AW-1:0]    EX_rd_addr_i,
    input  logic [AW-1:0]    ID_rs1_addr_i,
    input  logic [AW-1:0]    ID_rs2_addr_i,
    input  logic             MEM_reg_wr_en_i,
    input  logic             WB_reg_wr_en_i,
    input  logic             ID_rs1_used_i,
    input  logic             ID_rs2_used_i,
    input  logic             EX_load_i,
    input  logic             MEM_dmem_req_i,
    input  logic             dmem_ack_i,
    input  logic             EX_mdu_start_i,
    input  logic             mdu_done_i,
    input  logic             EX_pc_src_i,
    input  logic             ID_trap_valid_i,
    input  logic             EX_trap_valid_i,
    input  logic             MEM_trap_valid_i,
    input  logic             WB_trap_valid_i,

    output logic [1:0]       EX_forward_a_o,
    output logic [1:0]       EX_forward_b_o,
    output logic             IF_stall_o,
    output logic             ID_stall_o,
    output logic             EX_stall_o,
    output logic             MEM_stall_o,
    output logic             ID_flush_o,
    output logic             EX_flush_o,
    output logic             MEM_flush_o,
    output logic             WB_flush_o,
    output logic             mdu_kill_o,
    output logic             dmem_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    // Wait counter only has to reach DMEM_TIMEOUT; it never counts past it.
    localparam int unsigned          c_WCNT_W   = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [c_WCNT_W-1:0]  c_WAIT_MAX = c_WCNT_W'(DMEM_TIMEOUT);

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    fwd_sel_t w_fwd_a;
    fwd_sel_t w_fwd_b;

    dtcore32_fwd_sel #(
        .AW (AW)
    ) u_fwd_a (
        .i_rs_addr       (EX_rs1_addr_i),
        .i_mem_rd_addr   (MEM_rd_addr_i),
        .i_mem_reg_wr_en (MEM_reg_wr_en_i),
        .i_wb_rd_addr    (WB_rd_addr_i),
        .i_wb_reg_wr_en  (WB_reg_wr_en_i),
        .o_fwd_sel       (w_fwd_a)
    );

    dtcore32_fwd_sel #(
        .AW (AW)
    ) u_fwd_b (
        .i_rs_addr       (EX_rs2_addr_i),
        .i_mem_rd_addr   (MEM_rd_addr_i),
        .i_mem_reg_wr_en (MEM_reg_wr_en_i),
        .i_wb_rd_addr    (WB_rd_addr_i),
        .i_wb_reg_wr_en  (WB_reg_wr_en_i),
        .o_fwd_sel       (w_fwd_b)
    );

    assign EX_forward_a_o = w_fwd_a;
    assign EX_forward_b_o = w_fwd_b;

    // ------------------------------------------------------------------
    // Load-use detection. Sources the ID instruction does not read, and a
    // load targeting x0, can never create a dependency.
    // ------------------------------------------------------------------
    logic w_rs1_dep;
    logic w_rs2_dep;
    logic w_load_use;

    assign w_rs1_dep  = ID_rs1_used_i & (ID_rs1_addr_i == EX_rd_addr_i);
    assign w_rs2_dep  = ID_rs2_used_i & (ID_rs2_addr_i == EX_rd_addr_i);
    assign w_load_use = EX_load_i & (w_rs1_dep | w_rs2_dep) & (EX_rd_addr_i != '0);

    // ------------------------------------------------------------------
    // Data-memory wait tracking
    // ------------------------------------------------------------------
    dmem_state_t             r_dmem_state;
    logic [c_WCNT_W-1:0]     r_wait_cnt;
    logic                    w_wait_expired;
    logic                    w_dmem_stall;

    assign w_wait_expired = (r_dmem_state == WAIT) && (r_wait_cnt == c_WAIT_MAX);

    // The expiry cycle releases the stall so the access is abandoned; an
    // acknowledge on that same cycle still wins and suppresses the pulse.
    assign w_dmem_stall   = MEM_dmem_req_i & ~dmem_ack_i & ~w_wait_expired;
    assign dmem_timeout_o = w_wait_expired & ~dmem_ack_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dmem_state <= IDLE;
            r_wait_cnt   <= '0;
        end else begin
            case (r_dmem_state)
                IDLE: begin
                    if (MEM_dmem_req_i && !dmem_ack_i) begin
                        r_dmem_state <= WAIT;
                        r_wait_cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (dmem_ack_i || w_wait_expired) begin
                        r_dmem_state <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WCNT_W'(1);
                    end
                end
                default: begin
                    r_dmem_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // MDU busy tracking and kill. The op is held in EX while busy, so the
    // start input and the busy flag together describe an active op.
    // ------------------------------------------------------------------
    logic r_mdu_busy;
    logic w_mdu_active;
    logic w_mdu_kill;
    logic w_mdu_stall;

    assign w_mdu_active = r_mdu_busy | EX_mdu_start_i;

    // A trap in MEM/WB redirects the pipe, so the MDU result is unwanted.
    // While the data memory stalls, MEM/WB are frozen and the trap has not
    // taken effect yet, so the kill waits.
    assign w_mdu_kill  = (MEM_trap_valid_i | WB_trap_valid_i) & w_mdu_active & ~w_dmem_stall;
    assign w_mdu_stall = w_mdu_active & ~mdu_done_i & ~w_mdu_kill;
    assign mdu_kill_o  = w_mdu_kill;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mdu_busy <= 1'b0;
        end else if (mdu_done_i || w_mdu_kill) begin
            r_mdu_busy <= 1'b0;
        end else if (EX_mdu_start_i && !r_mdu_busy) begin
            r_mdu_busy <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stall hierarchy. Each stall source freezes the registers up to the
    // stage it blocks and inserts a bubble into the next register down.
    // ------------------------------------------------------------------
    logic w_if_stall;
    logic w_id_stall;
    logic w_ex_stall;
    logic w_mem_stall;
    logic w_wb_bubble;
    logic w_mem_bubble;
    logic w_ex_bubble;

    assign w_mem_stall  = w_dmem_stall;
    assign w_ex_stall   = w_dmem_stall | w_mdu_stall;
    assign w_id_stall   = w_ex_stall | w_load_use;
    assign w_if_stall   = w_id_stall;

    assign w_wb_bubble  = w_dmem_stall;
    assign w_mem_bubble = w_mdu_stall & ~w_dmem_stall;
    assign w_ex_bubble  = w_load_use & ~w_mdu_stall & ~w_dmem_stall;

    assign IF_stall_o  = w_if_stall;
    assign ID_stall_o  = w_id_stall;
    assign EX_stall_o  = w_ex_stall;
    assign MEM_stall_o = w_mem_stall;

    // ------------------------------------------------------------------
    // Flushes. A trap clears the register entering its stage and every
    // younger one. A held register cannot also be cleared; the request is
    // simply re-presented once the stall drops, because the trap or
    // redirect input is still asserted then.
    // ------------------------------------------------------------------
    logic w_id_flush_req;
    logic w_ex_flush_req;
    logic w_mem_flush_req;
    logic w_wb_flush_req;

    assign w_wb_flush_req  = WB_trap_valid_i | w_wb_bubble;
    assign w_mem_flush_req = WB_trap_valid_i | MEM_trap_valid_i | w_mem_bubble;
    assign w_ex_flush_req  = WB_trap_valid_i | MEM_trap_valid_i | EX_trap_valid_i
                           | EX_pc_src_i | w_ex_bubble;
    assign w_id_flush_req  = WB_trap_valid_i | MEM_trap_valid_i | EX_trap_valid_i
                           | ID_trap_valid_i | EX_pc_src_i;

    assign ID_flush_o  = w_id_flush_req  & ~w_id_stall;
    assign EX_flush_o  = w_ex_flush_req  & ~w_ex_stall;
    assign MEM_flush_o = w_mem_flush_req & ~w_mem_stall;
    assign WB_flush_o  = w_wb_flush_req;

    // ------------------------------------------------------------------
    // Front-end stall cycle counter, free-running with natural wrap.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_if_stall) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cycles_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dtcore32_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtcore32_hazard_ctrl
// Description : Self-checking bench for dtcore32_hazard_ctrl. Directed
//               scenarios plus a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtcore32_hazard_ctrl;

    localparam int AW    = 5;
    localparam int TMO   = 3;
    localparam int CNT_W = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] EX_rs1_addr_i, EX_rs2_addr_i, MEM_rd_addr_i, WB_rd_addr_i;
    logic [AW-1:0] EX_rd_addr_i, ID_rs1_addr_i, ID_rs2_addr_i;
    logic          MEM_reg_wr_en_i, WB_reg_wr_en_i, ID_rs1_used_i, ID_rs2_used_i;
    logic          EX_load_i, MEM_dmem_req_i, dmem_ack_i, EX_mdu_start_i, mdu_done_i;
    logic          EX_pc_src_i, ID_trap_valid_i, EX_trap_valid_i, MEM_trap_valid_i, WB_trap_valid_i;
    logic [1:0]    EX_forward_a_o, EX_forward_b_o;
    logic          IF_stall_o, ID_stall_o, EX_stall_o, MEM_stall_o;
    logic          ID_flush_o, EX_flush_o, MEM_flush_o, WB_flush_o;
    logic          mdu_kill_o, dmem_timeout_o;
    logic [CNT_W-1:0] stall_cycles_o;

    int n_vec = 0;
    int n_err = 0;

    dtcore32_hazard_ctrl #(
        .AW           (AW),
        .DMEM_TIMEOUT (TMO),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .EX_rs1_addr_i    (EX_rs1_addr_i),
        .EX_rs2_addr_i    (EX_rs2_addr_i),
        .MEM_rd_addr_i    (MEM_rd_addr_i),
        .WB_rd_addr_i     (WB_rd_addr_i),
        .EX_rd_addr_i     (EX_rd_addr_i),
        .ID_rs1_addr_i    (ID_rs1_addr_i),
        .ID_rs2_addr_i    (ID_rs2_addr_i),
        .MEM_reg_wr_en_i  (MEM_reg_wr_en_i),
        .WB_reg_wr_en_i   (WB_reg_wr_en_i),
        .ID_rs1_used_i    (ID_rs1_used_i),
        .ID_rs2_used_i    (ID_rs2_used_i),
        .EX_load_i        (EX_load_i),
        .MEM_dmem_req_i   (MEM_dmem_req_i),
        .dmem_ack_i       (dmem_ack_i),
        .EX_mdu_start_i   (EX_mdu_start_i),
        .mdu_done_i       (mdu_done_i),
        .EX_pc_src_i      (EX_pc_src_i),
        .ID_trap_valid_i  (ID_trap_valid_i),
        .EX_trap_valid_i  (EX_trap_valid_i),
        .MEM_trap_valid_i (MEM_trap_valid_i),
        .WB_trap_valid_i  (WB_trap_valid_i),
        .EX_forward_a_o   (EX_forward_a_o),
        .EX_forward_b_o   (EX_forward_b_o),
        .IF_stall_o       (IF_stall_o),
        .ID_stall_o       (ID_stall_o),
        .EX_stall_o       (EX_stall_o),
        .MEM_stall_o      (MEM_stall_o),
        .ID_flush_o       (ID_flush_o),
        .EX_flush_o       (EX_flush_o),
        .MEM_flush_o      (MEM_flush_o),
        .WB_flush_o       (WB_flush_o),
        .mdu_kill_o       (mdu_kill_o),
        .dmem_timeout_o   (dmem_timeout_o),
        .stall_cycles_o   (stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    // {IF,ID,EX,MEM stall, ID,EX,MEM,WB flush}
    logic [7:0]  w_sf;
    logic [13:0] w_all;
    assign w_sf  = {IF_stall_o, ID_stall_o, EX_stall_o, MEM_stall_o,
                    ID_flush_o, EX_flush_o, MEM_flush_o, WB_flush_o};
    assign w_all = {EX_forward_a_o, EX_forward_b_o, w_sf, mdu_kill_o, dmem_timeout_o};

    task automatic clear_inputs();
        EX_rs1_addr_i = '0; EX_rs2_addr_i = '0; MEM_rd_addr_i = '0; WB_rd_addr_i = '0;
        EX_rd_addr_i = '0; ID_rs1_addr_i = '0; ID_rs2_addr_i = '0;
        MEM_reg_wr_en_i = 0; WB_reg_wr_en_i = 0; ID_rs1_used_i = 0; ID_rs2_used_i = 0;
        EX_load_i = 0; MEM_dmem_req_i = 0; dmem_ack_i = 0; EX_mdu_start_i = 0; mdu_done_i = 0;
        EX_pc_src_i = 0; ID_trap_valid_i = 0; EX_trap_valid_i = 0;
        MEM_trap_valid_i = 0; WB_trap_valid_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        clear_inputs();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_inputs();
        #2;
        n_vec++;
        if (w_all !== 14'd0) begin
            n_err++; $display("FAIL reset_outputs: got %b expected %b", w_all, 14'd0);
        end
        n_vec++;
        if (stall_cycles_o !== 8'd0) begin
            n_err++; $display("FAIL reset_counter: got %0d expected 0", stall_cycles_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #2;
        n_vec++;
        if (w_all !== 14'd0) begin
            n_err++; $display("FAIL idle_outputs: got %b expected %b", w_all, 14'd0);
        end
    endtask

    task automatic test_forwarding();
        int rs1 [5] = '{5, 5, 0, 7, 7};
        int rs2 [5] = '{6, 5, 0, 9, 7};
        int mrd [5] = '{5, 5, 0, 9, 7};
        int mwe [5] = '{1, 0, 1, 1, 0};
        int wrd [5] = '{5, 5, 0, 7, 7};
        int wwe [5] = '{1, 1, 1, 1, 0};
        logic [3:0] exp [5] = '{4'b10_00, 4'b01_01, 4'b00_00, 4'b01_10, 4'b00_00};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            EX_rs1_addr_i = AW'(rs1[i]); EX_rs2_addr_i = AW'(rs2[i]);
            MEM_rd_addr_i = AW'(mrd[i]); MEM_reg_wr_en_i = mwe[i][0];
            WB_rd_addr_i  = AW'(wrd[i]); WB_reg_wr_en_i  = wwe[i][0];
            #2;
            n_vec++;
            if ({EX_forward_a_o, EX_forward_b_o} !== exp[i]) begin
                n_err++;
                $display("FAIL forward_row%0d: got %b expected %b", i,
                         {EX_forward_a_o, EX_forward_b_o}, exp[i]);
            end
        end
    endtask

    task automatic test_load_use();
        int ld  [5] = '{1, 1, 1, 0, 1};
        int erd [5] = '{3, 0, 3, 3, 4};
        int r1  [5] = '{0, 0, 1, 3, 4};
        int r1u [5] = '{0, 1, 1, 1, 1};
        int r2  [5] = '{3, 0, 3, 3, 2};
        int r2u [5] = '{1, 1, 0, 1, 0};
        logic [7:0] exp [5] = '{8'b1100_0100, 8'h00, 8'h00, 8'h00, 8'b1100_0100};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            EX_load_i = ld[i][0]; EX_rd_addr_i = AW'(erd[i]);
            ID_rs1_addr_i = AW'(r1[i]); ID_rs1_used_i = r1u[i][0];
            ID_rs2_addr_i = AW'(r2[i]); ID_rs2_used_i = r2u[i][0];
            #2;
            n_vec++;
            if (w_sf !== exp[i]) begin
                n_err++; $display("FAIL load_use_row%0d: got %b expected %b", i, w_sf, exp[i]);
            end
        end
    endtask

    task automatic test_dmem_ack();
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            MEM_dmem_req_i = 1'b1;
            dmem_ack_i     = (i >= 3);
            #2;
            exp = (i < 3) ? 8'b1111_0001 : 8'h00;
            n_vec++;
            if ({w_sf, dmem_timeout_o} !== {exp, 1'b0}) begin
                n_err++;
                $display("FAIL dmem_ack_cycle%0d: got %b expected %b", i, {w_sf, dmem_timeout_o}, {exp, 1'b0});
            end
        end
        @(negedge clk_i);
        clear_inputs();
        #2;
        n_vec++;
        if (stall_cycles_o !== 8'd3) begin
            n_err++; $display("FAIL dmem_ack_count: got %0d expected 3", stall_cycles_o);
        end
    endtask

    task automatic test_dmem_timeout();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            MEM_dmem_req_i = 1'b1;
            dmem_ack_i     = 1'b0;
            #2;
            n_vec++;
            if ({w_sf, dmem_timeout_o} !== ((i < 4) ? 9'b1111_0001_0 : 9'b0000_0000_1)) begin
                n_err++;
                $display("FAIL timeout_cycle%0d: got %b expected %b", i, {w_sf, dmem_timeout_o},
                         (i < 4) ? 9'b1111_0001_0 : 9'b0000_0000_1);
            end
        end
        @(negedge clk_i);
        clear_inputs();
        #2;
        n_vec++;
        if ({stall_cycles_o, dmem_timeout_o} !== {8'd4, 1'b0}) begin
            n_err++;
            $display("FAIL timeout_count: got cnt=%0d pulse=%b expected cnt=4 pulse=0",
                     stall_cycles_o, dmem_timeout_o);
        end
        // An acknowledge on the expiry cycle is a normal completion.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            MEM_dmem_req_i = 1'b1;
            dmem_ack_i     = (i == 4);
            #2;
            n_vec++;
            if ({w_sf, dmem_timeout_o} !== ((i < 4) ? 9'b1111_0001_0 : 9'b0)) begin
                n_err++;
                $display("FAIL ack_on_expiry_cycle%0d: got %b expected %b", i, {w_sf, dmem_timeout_o},
                         (i < 4) ? 9'b1111_0001_0 : 9'b0);
            end
        end
    endtask

    task automatic test_mdu();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            EX_mdu_start_i = (i < 6);
            mdu_done_i     = (i == 5);
            #2;
            n_vec++;
            if ({w_sf, mdu_kill_o} !== ((i < 5) ? 9'b1110_0010_0 : 9'b0)) begin
                n_err++;
                $display("FAIL mdu_cycle%0d: got %b expected %b", i, {w_sf, mdu_kill_o},
                         (i < 5) ? 9'b1110_0010_0 : 9'b0);
            end
        end
        n_vec++;
        if (stall_cycles_o !== 8'd5) begin
            n_err++; $display("FAIL mdu_count: got %0d expected 5", stall_cycles_o);
        end
        // Trap in WB on the third cycle kills the op and clears busy.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            EX_mdu_start_i  = (i < 3);
            WB_trap_valid_i = (i == 2);
            #2;
            n_vec++;
            if ({w_sf, mdu_kill_o} !== ((i < 2) ? 9'b1110_0010_0 : (i == 2) ? 9'b0000_1111_1 : 9'b0)) begin
                n_err++;
                $display("FAIL mdu_kill_cycle%0d: got %b expected %b", i, {w_sf, mdu_kill_o},
                         (i < 2) ? 9'b1110_0010_0 : (i == 2) ? 9'b0000_1111_1 : 9'b0);
            end
        end
    endtask

    task automatic test_redirect_under_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            MEM_dmem_req_i = 1'b1;
            dmem_ack_i     = (i == 2);
            EX_pc_src_i    = 1'b1;
            #2;
            n_vec++;
            if (w_sf !== ((i < 2) ? 8'b1111_0001 : 8'b0000_1100)) begin
                n_err++;
                $display("FAIL redirect_cycle%0d: got %b expected %b", i, w_sf,
                         (i < 2) ? 8'b1111_0001 : 8'b0000_1100);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            MEM_dmem_req_i = 1'b1;
            EX_mdu_start_i = 1'b1;
        end
        #2;
        rst_i = 1'b1;
        #1;
        n_vec++;
        if (stall_cycles_o !== 8'd0) begin
            n_err++; $display("FAIL async_reset_count: got %0d expected 0", stall_cycles_o);
        end
        clear_inputs();
        @(negedge clk_i);
        rst_i = 1'b0;
        #2;
        n_vec++;
        if (w_all !== 14'd0) begin
            n_err++; $display("FAIL async_reset_busy: got %b expected 0", w_all);
        end
        // Wait counter must restart: full four-cycle stall then the pulse.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            MEM_dmem_req_i = 1'b1;
            #2;
            n_vec++;
            if ({w_sf, dmem_timeout_o} !== ((i < 4) ? 9'b1111_0001_0 : 9'b0000_0000_1)) begin
                n_err++;
                $display("FAIL after_reset_wait%0d: got %b expected %b", i, {w_sf, dmem_timeout_o},
                         (i < 4) ? 9'b1111_0001_0 : 9'b0000_0000_1);
            end
        end
    endtask

    function automatic logic [1:0] model_fwd(logic [AW-1:0] rs, logic [AW-1:0] mrd, logic mwe,
                                             logic [AW-1:0] wrd, logic wwe);
        if (rs == 0) return 2'b00;
        if (mwe && mrd == rs) return 2'b10;
        if (wwe && wrd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic test_random();
        int  age;     // cycles the current dmem access has been waiting; 0 when none
        bit  busy;
        int  cnt;
        int  n_stl, deep;
        bit  dst, to, lu, kill, mst, req;
        logic [13:0] exp;
        do_reset();
        age = 0; busy = 0; cnt = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk_i);
            EX_rs1_addr_i = AW'($urandom_range(0, 3)); EX_rs2_addr_i = AW'($urandom_range(0, 3));
            MEM_rd_addr_i = AW'($urandom_range(0, 3)); WB_rd_addr_i  = AW'($urandom_range(0, 3));
            EX_rd_addr_i  = AW'($urandom_range(0, 3)); ID_rs1_addr_i = AW'($urandom_range(0, 3));
            ID_rs2_addr_i = AW'($urandom_range(0, 3));
            MEM_reg_wr_en_i  = ($urandom_range(0, 99) < 60);
            WB_reg_wr_en_i   = ($urandom_range(0, 99) < 60);
            ID_rs1_used_i    = ($urandom_range(0, 99) < 50);
            ID_rs2_used_i    = ($urandom_range(0, 99) < 50);
            EX_load_i        = ($urandom_range(0, 99) < 30);
            MEM_dmem_req_i   = ($urandom_range(0, 99) < 40);
            dmem_ack_i       = ($urandom_range(0, 99) < 35);
            EX_mdu_start_i   = ($urandom_range(0, 99) < 25);
            mdu_done_i       = ($urandom_range(0, 99) < 25);
            EX_pc_src_i      = ($urandom_range(0, 99) < 10);
            ID_trap_valid_i  = ($urandom_range(0, 99) < 5);
            EX_trap_valid_i  = ($urandom_range(0, 99) < 5);
            MEM_trap_valid_i = ($urandom_range(0, 99) < 5);
            WB_trap_valid_i  = ($urandom_range(0, 99) < 5);
            #2;
            // Behavioural expectation
            req  = MEM_dmem_req_i;
            to   = (age == TMO + 1) && !dmem_ack_i;
            dst  = req && !dmem_ack_i && (age != TMO + 1);
            lu   = EX_load_i && EX_rd_addr_i != 0 &&
                   ((ID_rs1_used_i && ID_rs1_addr_i == EX_rd_addr_i) ||
                    (ID_rs2_used_i && ID_rs2_addr_i == EX_rd_addr_i));
            kill = (MEM_trap_valid_i || WB_trap_valid_i) && (busy || EX_mdu_start_i) && !dst;
            mst  = (busy || EX_mdu_start_i) && !mdu_done_i && !kill;
            // Number of front registers held (PC=0, IF-ID=1, ID-EX=2, EX-MEM=3).
            n_stl = dst ? 4 : mst ? 3 : lu ? 2 : 0;
            deep  = WB_trap_valid_i ? 4 : MEM_trap_valid_i ? 3 : EX_trap_valid_i ? 2 :
                    ID_trap_valid_i ? 1 : 0;
            exp = '0;
            exp[13:12] = model_fwd(EX_rs1_addr_i, MEM_rd_addr_i, MEM_reg_wr_en_i, WB_rd_addr_i, WB_reg_wr_en_i);
            exp[11:10] = model_fwd(EX_rs2_addr_i, MEM_rd_addr_i, MEM_reg_wr_en_i, WB_rd_addr_i, WB_reg_wr_en_i);
            for (int k = 0; k < 4; k++) exp[9-k] = (k < n_stl);
            for (int k = 1; k <= 4; k++)
                exp[6-k] = ((k <= deep) || (EX_pc_src_i && k <= 2) || (n_stl != 0 && k == n_stl))
                           && !(k < n_stl);
            exp[1] = kill;
            exp[0] = to;
            n_vec++;
            if (w_all !== exp) begin
                n_err++; $display("FAIL random_outputs@%0d: got %b expected %b", c, w_all, exp);
            end
            n_vec++;
            if (stall_cycles_o !== CNT_W'(cnt)) begin
                n_err++; $display("FAIL random_counter@%0d: got %0d expected %0d", c, stall_cycles_o, cnt);
            end
            // Advance model state to the next cycle
            if (age == 0)                               age = (req && !dmem_ack_i) ? 1 : 0;
            else if (dmem_ack_i || age == TMO + 1)      age = 0;
            else                                        age = age + 1;
            if (mdu_done_i || kill)  busy = 0;
            else if (EX_mdu_start_i) busy = 1;
            if (n_stl != 0) cnt = (cnt + 1) % 256;
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_dmem_ack();
        test_dmem_timeout();
        test_mdu();
        test_redirect_under_stall();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dtcore32_hazard_ctrl.md
# dtcore32_hazard_ctrl

Parametrised pipeline hazard controller for the five-stage dtcore32 core. It replaces the fixed one-cycle data-memory stall with a variable-latency request/ack wait that has a timeout. It adds a multi-cycle MDU (mul/div) busy stall with abort-on-trap, suppresses load-use stalls for x0 and unused sources, and exposes a stall-cycle performance counter. It sits beside the pipeline registers and drives their stall/flush controls and the EX forwarding muxes.

## Interface
- AW, 5: register address width
- DMEM_TIMEOUT, 255: max wait cycles for dmem_ack_i before abort, ≥1
- CNT_W, 32: stall counter width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- EX_rs1_addr_i, EX_rs2_addr_i, MEM_rd_addr_i, WB_rd_addr_i, EX_rd_addr_i, ID_rs1_addr_i, ID_rs2_addr_i  in  AW  register addresses
- MEM_reg_wr_en_i, WB_reg_wr_en_i  in  1  stage writes rd
- ID_rs1_used_i, ID_rs2_used_i  in  1  ID instruction reads that source
- EX_load_i  in  1  load in EX
- MEM_dmem_req_i  in  1  MEM instruction has a data-memory access outstanding
- dmem_ack_i  in  1  data memory completes access this cycle
- EX_mdu_start_i  in  1  MDU op in EX
- mdu_done_i  in  1  MDU result ready this cycle
- EX_pc_src_i  in  1  taken branch/jump resolved in EX
- ID_trap_valid_i, EX_trap_valid_i, MEM_trap_valid_i, WB_trap_valid_i  in  1  trap in stage
- EX_forward_a_o, EX_forward_b_o  out  2  00 none, 01 WB, 10 MEM
- IF_stall_o, ID_stall_o, EX_stall_o, MEM_stall_o  out  1  hold PC / IF-ID / ID-EX / EX-MEM register
- ID_flush_o, EX_flush_o, MEM_flush_o, WB_flush_o  out  1  clear IF-ID / ID-EX / EX-MEM / MEM-WB register
- mdu_kill_o  out  1  abort in-flight MDU op
- dmem_timeout_o  out  1  one-cycle pulse on dmem timeout
- stall_cycles_o  out  CNT_W  count of cycles with IF_stall_o high

## Operation
- Forwarding, per source: MEM match (wr_en, addr equal, addr≠0) wins over WB match; otherwise 00.
- load_use = EX_load_i & ((ID_rs1_used_i & ID_rs1_addr_i==EX_rd_addr_i) | (rs2 likewise)) & EX_rd_addr_i≠0.
- Dmem FSM, states IDLE/WAIT:
  - IDLE→WAIT when MEM_dmem_req_i & ~dmem_ack_i.
  - WAIT→IDLE on dmem_ack_i, or when wait counter = DMEM_TIMEOUT. The timeout exit pulses dmem_timeout_o.
  - Counter clears on entry to WAIT and increments each WAIT cycle.
- dmem_stall = MEM_dmem_req_i & ~dmem_ack_i & ~(WAIT & cnt==DMEM_TIMEOUT). A zero-wait ack produces no stall.
- mdu_busy flag:
  - Set when EX_mdu_start_i & ~mdu_done_i & ~mdu_busy.
  - Cleared by mdu_done_i or mdu_kill_o.
  - mdu_stall = (mdu_busy | EX_mdu_start_i) & ~mdu_done_i & ~mdu_kill_o.
- Stall hierarchy, highest wins:
  - dmem_stall: IF/ID/EX/MEM stall, WB_flush bubble.
  - mdu_stall: IF/ID/EX stall, MEM_flush bubble.
  - load_use: IF/ID stall, EX_flush bubble.
- Flushes:
  - EX_pc_src_i flushes ID and EX.
  - A trap in stage S flushes the register entering S and every younger register.
  - Any flush of a register whose stall is asserted is suppressed. It is re-evaluated while the trap input persists.
- mdu_kill_o = (MEM_trap_valid_i | WB_trap_valid_i | EX_pc_src_i-irrelevant:0) … defined as (MEM_trap_valid_i | WB_trap_valid_i) & (mdu_busy | EX_mdu_start_i) & ~dmem_stall.
- All outputs except the FSM, mdu_busy and the counter are combinational.

## Timing
- Reset values:
  - FSM=IDLE, counter=0, mdu_busy=0, stall_cycles_o=0.
  - With all inputs 0, every output is 0.
- Forward, stall, flush and kill are same-cycle combinational.
- The timeout pulse occurs on the cycle the counter equals DMEM_TIMEOUT. The stall releases in that same cycle, so the total stall is DMEM_TIMEOUT+1 cycles.
- An ack arriving on the timeout cycle counts as an ack: no pulse.
- stall_cycles_o updates one cycle after the stall and wraps modulo 2^CNT_W.
- Reset asserted mid-wait returns the FSM to IDLE immediately and clears mdu_busy.

## Structure
- dtcore32_pkg holds:
  - fwd_sel_t: FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - dmem_state_t: IDLE, WAIT.
- Sub-module dtcore32_fwd_sel computes one source's select. It is instantiated twice, for a and b.

## Test plan
- EX_rs1=5, MEM_rd=5 wr, WB_rd=5 wr → forward_a=10; EX_rs1=0 with matching rd → 00.
- EX_load, EX_rd=3, ID_rs2=3 used → IF/ID stall, EX_flush one cycle; EX_rd=0 or rs2 unused → no stall.
- MEM_dmem_req with ack on the 4th cycle → IF..MEM stall 3 cycles, WB_flush 3 cycles, FSM returns to IDLE; ack on the request cycle → 0 stall.
- DMEM_TIMEOUT=3, never ack → 4 stall cycles, dmem_timeout_o pulses once, stall_cycles_o=4.
- EX_mdu_start, done after 5 cycles → IF..EX stall 5 cycles with MEM_flush. WB_trap at cycle 2 → mdu_kill_o high, all four flushes asserted, busy cleared.
- EX_pc_src during dmem_stall → no ID/EX flush until the stall drops, then both flush.
